mem_ram_ctrl: RTL

- MEM-stage initiator for the data RAM. It turns the MEM stage's load/store request into a handshaked RAM transaction, stalls the pipeline until the RAM responds, and presents read data for MEMWB to capture.
- It is the request/issue side of the RAM data path. The pipeline register between MEM and WB only samples the returned data.
- Multi-cycle FSM with a timeout counter.

---
 rtl/mem_ram_ctrl_pkg.sv | 14 +
 rtl/mem_store_align.sv | 15 +
 rtl/mem_ram_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_ram_ctrl_pkg.sv
// rtl/mem_ram_ctrl_pkg.sv - shared bus widths and state encoding for the MEM-stage RAM controller
package mem_ram_ctrl_pkg;

    localparam int DATA_BUS_WIDTH    = 32;
    localparam int ADDR_BUS_WIDTH    = 32;
    localparam int MEM_SEL_BUS_WIDTH = 4;

    typedef enum logic [1:0] {
        MRC_IDLE = 2'd0,
        MRC_REQ  = 2'd1,
        MRC_DONE = 2'd2
    } mrc_state_e;

endpackage

// File: rtl/mem_store_align.sv
// rtl/mem_store_align.sv - byte-lane shifter placing right-justified store data on its address lane
module mem_store_align
    import mem_ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS_WIDTH
) (
    input  logic [1:0]            byte_offset,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] shifted_data
);

    // Lane k of the word holds byte address offset k, so shift left by 8*offset.
    assign shifted_data = data << {byte_offset, 3'b000};

endmodule

// File: rtl/mem_ram_ctrl.sv
// rtl/mem_ram_ctrl.sv - MEM-stage initiator that issues handshaked data-RAM accesses and stalls until done
module mem_ram_ctrl
    import mem_ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_BUS_WIDTH,
    parameter int ADDR_WIDTH     = ADDR_BUS_WIDTH,
    parameter int SEL_WIDTH      = MEM_SEL_BUS_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_in,
    input  logic                  mem_read_flag_in,
    input  logic                  mem_write_flag_in,
    input  logic [SEL_WIDTH-1:0]  mem_sel_in,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    input  logic                  ram_ready,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  ram_en,
    output logic [SEL_WIDTH-1:0]  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  stall_request,
    output logic [DATA_WIDTH-1:0] ram_read_data_out,
    output logic                  bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mrc_state_e            state;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  xfer_write;
    logic                  abandoned;
    logic                  req;
    logic                  abandon_now;
    logic [DATA_WIDTH-1:0] shifted_wdata;

    // A write wins when both flags are set; flush cancels the instruction before issue.
    assign req         = (mem_read_flag_in | mem_write_flag_in) & ~flush;
    // A flush arriving in the completing cycle still abandons the result.
    assign abandon_now = abandoned | flush;

    mem_store_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_store_align (
        .byte_offset  (address_in[1:0]),
        .data         (write_data_in),
        .shifted_data (shifted_wdata)
    );

    // Freeze the pipeline from the request cycle until the RAM answers or times out.
    always_comb begin
        stall_request = 1'b0;
        if (!rst) begin
            case (state)
                MRC_IDLE: stall_request = req;
                MRC_REQ:  stall_request = 1'b1;
                default:  stall_request = 1'b0;
            endcase
        end
    end

    // Access FSM: latch the request, hold it on the bus until ready or timeout, then present the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= MRC_IDLE;
            wait_cnt          <= '0;
            xfer_write        <= 1'b0;
            abandoned         <= 1'b0;
            ram_en            <= 1'b0;
            ram_write_en      <= '0;
            ram_addr          <= '0;
            ram_write_data    <= '0;
            ram_read_data_out <= '0;
            bus_error         <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                MRC_IDLE: begin
                    if (req) begin
                        state          <= MRC_REQ;
                        wait_cnt       <= '0;
                        abandoned      <= 1'b0;
                        xfer_write     <= mem_write_flag_in;
                        ram_en         <= 1'b1;
                        ram_write_en   <= mem_write_flag_in ? mem_sel_in : '0;
                        ram_addr       <= {address_in[ADDR_WIDTH-1:2], 2'b00};
                        ram_write_data <= shifted_wdata;
                    end
                end
                MRC_REQ: begin
                    if (flush) begin
                        abandoned <= 1'b1;
                    end
                    if (ram_ready) begin
                        ram_en       <= 1'b0;
                        ram_write_en <= '0;
                        if (!xfer_write && !abandon_now) begin
                            ram_read_data_out <= ram_read_data;
                        end
                        state <= abandon_now ? MRC_IDLE : MRC_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        ram_en       <= 1'b0;
                        ram_write_en <= '0;
                        bus_error    <= 1'b1;
                        if (!abandon_now) begin
                            ram_read_data_out <= '0;
                        end
                        state <= abandon_now ? MRC_IDLE : MRC_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MRC_DONE: begin
                    if (!stall_in) begin
                        state <= MRC_IDLE;
                    end
                end
                default: state <= MRC_IDLE;
            endcase
        end
    end

endmodule
